// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered AXI-stream output between NI requesters.
// Optional frame locking is enabled with the STREAM_ARB_LOCK_EN macro.
//
// state | meaning
// IDLE  | no owner; scan valids from rr_ptr for the next winner
// GRANT | owner streams up to BURST beats through the output register
module stream_rr_arbiter #(
   parameter int NI    = 4,
   parameter int DW    = 24,
   parameter int TIDW  = 8,
   parameter int BURST = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NI*DW-1:0]   s_axis_tdata,
   input  logic [NI-1:0]      s_axis_tvalid,
`ifdef STREAM_ARB_LOCK_EN
   input  logic [NI-1:0]      s_axis_tlock,
`endif
   output logic [NI-1:0]      s_axis_tready,
   output logic [DW-1:0]      m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic [TIDW-1:0]    m_axis_tid,
   output logic [NI-1:0]      grant
);

   localparam int IW = $clog2(NI);
   localparam int CW = $clog2(BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NI-1:0]   grant_q, grant_d;
   logic [CW-1:0]   beat_ctr_q, beat_ctr_d;
   logic [DW-1:0]   data_q, data_d;
   logic [TIDW-1:0] tid_q, tid_d;
   logic            valid_q, valid_d;

   logic [NI-1:0]   rot_vld;
   logic [IW-1:0]   offset;
   logic [IW:0]     win_sum;
   logic [IW-1:0]   winner;
   logic            found;
   logic [DW-1:0]   own_data;
   logic            owner_valid;
   logic            in_ready;
   logic            in_hs;
   logic            out_hs;
   logic            burst_done;
   logic            release_now;
   logic [IW-1:0]   next_ptr;

`ifdef STREAM_ARB_LOCK_EN
   logic            lock_q, lock_d;
   logic            own_lock;
   assign own_lock = |(s_axis_tlock & grant_q);
`endif

   // rotate valids so rr_ptr lands on bit 0, then take the lowest set bit
   always_comb begin
      rot_vld = NI'({s_axis_tvalid, s_axis_tvalid} >> rr_ptr_q);
      offset  = '0;
      for (int i = NI - 1; i >= 0; i--) begin
         if (rot_vld[i]) offset = IW'(i);
      end
      found   = |rot_vld;
      win_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
      if (win_sum >= (IW+1)'(NI)) win_sum = win_sum - (IW+1)'(NI);
      winner  = win_sum[IW-1:0];
   end

   always_comb begin
      own_data = '0;
      for (int i = 0; i < NI; i++) begin
         if (grant_q[i]) own_data = s_axis_tdata[i*DW +: DW];
      end
   end

   assign owner_valid   = |(s_axis_tvalid & grant_q);
   assign in_ready      = !valid_q || m_axis_tready;
   assign s_axis_tready = (state_q == GRANT && in_ready) ? grant_q : '0;
   assign in_hs         = (state_q == GRANT) && owner_valid && in_ready;
   assign out_hs        = valid_q && m_axis_tready;
   assign burst_done    = (beat_ctr_q + CW'(1)) == CW'(BURST);
   assign next_ptr      = (owner_q == IW'(NI - 1)) ? '0 : owner_q + IW'(1);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      beat_ctr_d  = beat_ctr_q;
      data_d      = data_q;
      tid_d       = tid_q;
      valid_d     = valid_q;
      release_now = 1'b0;
`ifdef STREAM_ARB_LOCK_EN
      lock_d      = lock_q;
`endif

      if (in_hs) begin
         data_d  = own_data;
         tid_d   = TIDW'(owner_q);
         valid_d = 1'b1;
      end else if (out_hs) begin
         valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               state_d    = GRANT;
               owner_d    = winner;
               grant_d    = NI'(1) << winner;
               beat_ctr_d = '0;
`ifdef STREAM_ARB_LOCK_EN
               lock_d     = 1'b0;
`endif
            end
         end
         GRANT: begin
            if (in_hs) beat_ctr_d = beat_ctr_q + CW'(1);
`ifdef STREAM_ARB_LOCK_EN
            // a locked frame ignores the burst limit and valid gaps until its last beat
            if (in_hs && own_lock) begin
               lock_d     = 1'b1;
               beat_ctr_d = '0;
            end else if (in_hs && lock_q) begin
               lock_d      = 1'b0;
               release_now = 1'b1;
            end else if (!lock_q) begin
               release_now = !owner_valid || (in_hs && burst_done);
            end
`else
            release_now = !owner_valid || (in_hs && burst_done);
`endif
            if (release_now) begin
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         beat_ctr_q <= '0;
         data_q     <= '0;
         tid_q      <= '0;
         valid_q    <= 1'b0;
`ifdef STREAM_ARB_LOCK_EN
         lock_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         beat_ctr_q <= beat_ctr_d;
         data_q     <= data_d;
         tid_q      <= tid_d;
         valid_q    <= valid_d;
`ifdef STREAM_ARB_LOCK_EN
         lock_q     <= lock_d;
`endif
      end
   end

   assign m_axis_tdata  = data_q;
   assign m_axis_tvalid = valid_q;
   assign m_axis_tid    = tid_q;
   assign grant         = grant_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter: reset, round-robin order,
// single requester, backpressure and pointer wrap/skip.
module tb_stream_rr_arbiter;

   localparam int NI    = 4;
   localparam int DW    = 24;
   localparam int TIDW  = 8;
   localparam int BURST = 4;

   logic              clk;
   logic              rst;
   logic [NI*DW-1:0]  s_axis_tdata;
   logic [NI-1:0]     s_axis_tvalid;
   logic [NI-1:0]     s_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [TIDW-1:0]   m_axis_tid;
   logic [NI-1:0]     grant;
`ifdef STREAM_ARB_LOCK_EN
   logic [NI-1:0]     s_axis_tlock;
   assign s_axis_tlock = '0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] src_mem [NI][8];
   int            src_n   [NI];
   int            src_cnt [NI];
   logic [DW-1:0] exp_data[$];
   int            exp_tid [$];

   stream_rr_arbiter #(.NI(NI), .DW(DW), .TIDW(TIDW), .BURST(BURST)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
`ifdef STREAM_ARB_LOCK_EN
      .s_axis_tlock  (s_axis_tlock),
`endif
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tid    (m_axis_tid),
      .grant         (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_sources();
      for (int c = 0; c < NI; c++) begin
         if (src_cnt[c] < src_n[c]) begin
            s_axis_tvalid[c]           = 1'b1;
            s_axis_tdata[c*DW +: DW]   = src_mem[c][src_cnt[c]];
         end else begin
            s_axis_tvalid[c]           = 1'b0;
            s_axis_tdata[c*DW +: DW]   = '0;
         end
      end
   endtask

   // Sources advance on their own handshakes; every output beat is checked
   // against the expected queue. Returns first/last output-beat cycle indices
   // and the OR of all grant values seen.
   task automatic run_traffic(input int max_cycles, output int first_out,
                              output int last_out, output logic [NI-1:0] gseen);
      int            cyc;
      logic [NI-1:0] hs;
      bit            done;
      bit            srcs_done;
      first_out = -1;
      last_out  = -1;
      gseen     = '0;
      cyc       = 0;
      done      = 1'b0;
      for (int c = 0; c < NI; c++) src_cnt[c] = 0;
      m_axis_tready = 1'b1;
      drive_sources();
      #1;
      while (!done && cyc < max_cycles) begin
         hs    = s_axis_tvalid & s_axis_tready;
         gseen = gseen | grant;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_tid.size() == 0) begin
               chk("extra_beat", 32'(exp_tid.size()), 32'd1);
            end else begin
               chk("beat_tid", 32'(m_axis_tid), 32'(exp_tid.pop_front()));
               chk("beat_data", 32'(m_axis_tdata), 32'(exp_data.pop_front()));
            end
            if (grant != '0) chk("grant_vs_tid", 32'(grant), 32'd1 << m_axis_tid);
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
         end
         @(posedge clk); #1;
         for (int c = 0; c < NI; c++) if (hs[c]) src_cnt[c]++;
         drive_sources();
         #1;
         cyc++;
         srcs_done = 1'b1;
         for (int c = 0; c < NI; c++) if (src_cnt[c] != src_n[c]) srcs_done = 1'b0;
         done = srcs_done && (exp_tid.size() == 0);
      end
      chk("traffic_done", 32'(done), 32'd1);
   endtask

   int            f_out, l_out;
   logic [NI-1:0] gs;

   initial begin
      rst           = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = '0;
      m_axis_tready = 1'b0;
      #2;
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_tid", 32'(m_axis_tid), 32'd0);
      chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
      chk("rst_tready", 32'(s_axis_tready), 32'd0);
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b0;

      // load one ch2 beat into the output register and hold it with backpressure
      @(posedge clk); #1;
      s_axis_tvalid = 4'b0100;
      s_axis_tdata[2*DW +: DW] = 24'h5A5A5A;
      @(posedge clk); #1;
      chk("pre_rst_grant", 32'(grant), 32'h4);
      @(posedge clk); #1;
      chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("pre_rst_tid", 32'(m_axis_tid), 32'd2);
      chk("pre_rst_tdata", 32'(m_axis_tdata), 32'h5A5A5A);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("async_rst_grant", 32'(grant), 32'd0);
      chk("async_rst_tid", 32'(m_axis_tid), 32'd0);
      chk("async_rst_tdata", 32'(m_axis_tdata), 32'd0);
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      #2;
      rst = 1'b0;
      @(posedge clk); #1;

      // round-robin: all channels 8 beats each, groups of BURST, ch0 first
      for (int c = 0; c < NI; c++) begin
         src_n[c] = 8;
         for (int j = 0; j < 8; j++) src_mem[c][j] = {4'hA, 4'(c), 8'h5C, 8'(j)};
      end
      for (int g = 0; g < 8; g++) begin
         for (int b = 0; b < BURST; b++) begin
            exp_tid.push_back(g % NI);
            exp_data.push_back({4'hA, 4'(g % NI), 8'h5C, 8'((g / NI) * BURST + b)});
         end
      end
      run_traffic(100, f_out, l_out, gs);
      chk("rr_first_cycle", 32'(f_out), 32'd2);
      chk("rr_span_with_bubbles", 32'(l_out - f_out), 32'd38);
      chk("rr_grants_seen", 32'(gs), 32'hF);
      chk("rr_end_grant", 32'(grant), 32'd0);

      // single requester ch2, three beats
      for (int c = 0; c < NI; c++) src_n[c] = 0;
      src_n[2] = 3;
      src_mem[2][0] = 24'h000011;
      src_mem[2][1] = 24'h000022;
      src_mem[2][2] = 24'h000033;
      for (int j = 0; j < 3; j++) begin
         exp_tid.push_back(2);
         exp_data.push_back(24'(17 * (j + 1)));
      end
      run_traffic(40, f_out, l_out, gs);
      chk("single_grants_seen", 32'(gs), 32'h4);
      chk("single_span", 32'(l_out - f_out), 32'd2);
      chk("single_release_grant", 32'(grant), 32'd0);
      chk("single_release_tvalid", 32'(m_axis_tvalid), 32'd0);

      // rr_ptr=3, only ch1 valid: wrap to ch1; backpressure for 5 cycles
      s_axis_tdata  = '0;
      s_axis_tdata[1*DW +: DW] = 24'hABCDEF;
      s_axis_tvalid = 4'b0010;
      m_axis_tready = 1'b0;
      #1;
      chk("wrap_idle_grant", 32'(grant), 32'd0);
      chk("wrap_idle_tready", 32'(s_axis_tready), 32'd0);
      @(posedge clk); #1;
      chk("wrap_grant_ch1", 32'(grant), 32'h2);
      chk("wrap_tready_ch1", 32'(s_axis_tready), 32'h2);
      @(posedge clk); #1;
      s_axis_tdata[1*DW +: DW] = 24'h123456;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
         chk("bp_tdata", 32'(m_axis_tdata), 32'hABCDEF);
         chk("bp_tid", 32'(m_axis_tid), 32'd1);
         chk("bp_tready", 32'(s_axis_tready), 32'd0);
         if (k < 4) begin
            @(posedge clk); #1;
         end
      end
      m_axis_tready = 1'b1;
      #1;
      chk("bp_release_tready", 32'(s_axis_tready), 32'h2);
      @(posedge clk); #1;
      s_axis_tvalid = '0;
      #1;
      chk("bp_next_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("bp_next_tdata", 32'(m_axis_tdata), 32'h123456);
      chk("bp_next_grant", 32'(grant), 32'h2);
      @(posedge clk); #1;
      chk("drop_release_grant", 32'(grant), 32'd0);
      chk("drop_release_tvalid", 32'(m_axis_tvalid), 32'd0);

      // rr_ptr must now be 2: all valid -> ch2 wins
      s_axis_tvalid = 4'hF;
      #1;
      chk("ptr2_idle_grant", 32'(grant), 32'd0);
      @(posedge clk); #1;
      chk("ptr2_grant_ch2", 32'(grant), 32'h4);
      s_axis_tvalid = '0;
      @(posedge clk); #1;
      chk("ptr2_release_grant", 32'(grant), 32'd0);
      chk("ptr2_no_beat", 32'(m_axis_tvalid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
